// File: rtl/gcd_seq.sv
// Iterative subtract-based GCD engine with valid/ready handshakes on both sides.
// Define GCD_CYCLE_CNT_EN to add the iter_cnt port counting CALC cycles per job.
module gcd_seq #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] gcd_out,
  output logic         busy
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [W:0]   iter_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_result;
  logic         w_accept;
  logic         w_calcEnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A job ends when either operand hits zero or both become equal.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_calcEnd   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_nextState = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if ((r_a == '0) || (r_b == '0) || (r_a == r_b)) begin
          w_calcEnd   = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // The larger operand is always the minuend, so the subtraction never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a <= a_in;
      r_b <= b_in;
    end else if (r_state == S_CALC) begin
      if (w_calcEnd) begin
        r_result <= (r_a == '0) ? r_b : r_a;
      end else if (r_a > r_b) begin
        r_a <= r_a - r_b;
      end else begin
        r_b <= r_b - r_a;
      end
    end
  end

  assign gcd_out = r_result;

`ifdef GCD_CYCLE_CNT_EN
  logic [W:0] r_iterCnt;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_iterCnt <= '0;
    end else if (r_state == S_CALC) begin
      r_iterCnt <= r_iterCnt + 1'b1;
    end
  end

  assign iter_cnt = r_iterCnt;
`endif

endmodule
